// File: rtl/ifetch_unit_if.sv
// ---------------------------------------------------------------------------
// ifetch_unit_if
// Bundles the buses around the instruction fetch unit.
//   imem_*     : instruction memory read port (address out, word/fault back)
//   redirect_* : PC redirect from branch resolution / trap logic
//   id_*       : valid/ready packet channel towards decode
// Modports:
//   master : the fetch unit's view (drives imem_addr and the id_* packet)
//   slave  : the environment's view (memory, redirect source, decode)
// ---------------------------------------------------------------------------
interface ifetch_unit_if;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        imem_exc_en;
  logic [3:0]  imem_exc_code;
  logic [63:0] imem_exc_val;

  logic        redirect_en;
  logic [63:0] redirect_pc;

  logic        id_valid;
  logic        id_ready;
  logic [63:0] id_pc;
  logic [31:0] id_instr;
  logic        id_exc_en;
  logic [3:0]  id_exc_code;
  logic [63:0] id_exc_val;

  modport master (
    output imem_addr,
    input  imem_instr, imem_exc_en, imem_exc_code, imem_exc_val,
    input  redirect_en, redirect_pc,
    output id_valid, id_pc, id_instr, id_exc_en, id_exc_code, id_exc_val,
    input  id_ready
  );

  modport slave (
    input  imem_addr,
    output imem_instr, imem_exc_en, imem_exc_code, imem_exc_val,
    output redirect_en, redirect_pc,
    input  id_valid, id_pc, id_instr, id_exc_en, id_exc_code, id_exc_val,
    output id_ready
  );
endinterface

// File: rtl/ifetch_unit.sv
// ---------------------------------------------------------------------------
// ifetch_unit
// Owns the architectural fetch PC, drives the instruction memory read port
// and hands one fetched packet at a time to decode over valid/ready.
// After producing a faulted packet it stops fetching until redirected.
// Ports:
//   clk  : system clock, all state updates on the rising edge
//   rst  : synchronous active-high reset
//   bus  : ifetch_unit_if.master (imem_*, redirect_*, id_* signals)
// ---------------------------------------------------------------------------
module ifetch_unit #(
  parameter logic [63:0] RESET_PC  = 64'h0000_0000_8000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic           clk,
  input logic           rst,
  ifetch_unit_if.master bus
);

  localparam logic [0:0] ST_RUN        = 1'b0;
  localparam logic [0:0] ST_FAULT_HOLD = 1'b1;

  // Instruction-address-misaligned check done locally, independent of memory.
  function automatic logic is_misaligned(input logic [63:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

  logic [0:0]  state_r;
  logic [63:0] pc_r;
  logic        id_valid_r;
  logic [63:0] id_pc_r;
  logic [31:0] id_instr_r;
  logic        id_exc_en_r;
  logic [3:0]  id_exc_code_r;
  logic [63:0] id_exc_val_r;

  logic        slot_free_s;
  logic        nxt_exc_en_s;
  logic [3:0]  nxt_exc_code_s;
  logic [63:0] nxt_exc_val_s;
  logic [31:0] nxt_instr_s;

  // Build the packet that would be captured this cycle; misalignment wins over memory status.
  always_comb begin
    slot_free_s    = (!id_valid_r) || bus.id_ready;
    nxt_exc_en_s   = 1'b0;
    nxt_exc_code_s = 4'd0;
    nxt_exc_val_s  = 64'd0;
    nxt_instr_s    = NOP_INSTR;
    if (is_misaligned(pc_r)) begin
      nxt_exc_en_s   = 1'b1;
      nxt_exc_code_s = 4'd0;
      nxt_exc_val_s  = pc_r;
      nxt_instr_s    = NOP_INSTR;
    end else if (bus.imem_exc_en) begin
      nxt_exc_en_s   = 1'b1;
      nxt_exc_code_s = bus.imem_exc_code;
      nxt_exc_val_s  = bus.imem_exc_val;
      nxt_instr_s    = NOP_INSTR;
    end else begin
      nxt_exc_en_s   = 1'b0;
      nxt_exc_code_s = bus.imem_exc_code;
      nxt_exc_val_s  = bus.imem_exc_val;
      nxt_instr_s    = bus.imem_instr;
    end
  end

  // PC, fetch state and the registered decode packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_RUN;
      pc_r          <= RESET_PC;
      id_valid_r    <= 1'b0;
      id_pc_r       <= 64'd0;
      id_instr_r    <= NOP_INSTR;
      id_exc_en_r   <= 1'b0;
      id_exc_code_r <= 4'd0;
      id_exc_val_r  <= 64'd0;
    end else if (bus.redirect_en) begin
      // Flush: a coinciding handshake is already consumed, the memory
      // response of this cycle is simply not captured.
      state_r    <= ST_RUN;
      pc_r       <= bus.redirect_pc;
      id_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (slot_free_s) begin
            id_valid_r    <= 1'b1;
            id_pc_r       <= pc_r;
            id_instr_r    <= nxt_instr_s;
            id_exc_en_r   <= nxt_exc_en_s;
            id_exc_code_r <= nxt_exc_code_s;
            id_exc_val_r  <= nxt_exc_val_s;
            if (nxt_exc_en_s) begin
              // Keep the PC on the faulting address; only a redirect moves it.
              state_r <= ST_FAULT_HOLD;
            end else begin
              pc_r <= pc_r + 64'd4;
            end
          end
        end
        ST_FAULT_HOLD: begin
          if (id_valid_r && bus.id_ready) begin
            id_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r    <= ST_FAULT_HOLD;
          id_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_addr   = pc_r;
  assign bus.id_valid    = id_valid_r;
  assign bus.id_pc       = id_pc_r;
  assign bus.id_instr    = id_instr_r;
  assign bus.id_exc_en   = id_exc_en_r;
  assign bus.id_exc_code = id_exc_code_r;
  assign bus.id_exc_val  = id_exc_val_r;

endmodule
